// File: rtl/pc_pkg.sv
// Shared types and default parameters for the registered program counter
// with return stack (pc_pilha).
package pc_pkg;

  localparam int unsigned LARGURA_PADRAO     = 8;
  localparam int unsigned PROFUNDIDADE_PADRAO = 4;
  localparam int unsigned RESET_END_PADRAO    = 0;

  typedef enum logic [2:0] {
    SEL_ESPERA  = 3'd0,
    SEL_INC     = 3'd1,
    SEL_DESVIO  = 3'd2,
    SEL_CHAMADA = 3'd3,
    SEL_RETORNO = 3'd4
  } selEnd_t;

  // Pointer needs one extra bit so that "full" (ptr == depth) is representable.
  function automatic int unsigned larguraPtr(input int unsigned profundidade);
    return $clog2(profundidade) + 1;
  endfunction

  function automatic int unsigned larguraIdx(input int unsigned profundidade);
    return (profundidade > 1) ? $clog2(profundidade) : 1;
  endfunction

endpackage

// File: rtl/pilha_retorno.sv
// Return-address LIFO for pc_pilha. Pushes while full and pops while empty
// are ignored; the top entry is read combinationally from the registered pointer.
module pilha_retorno
  import pc_pkg::*;
#(
  parameter int unsigned LARGURA      = LARGURA_PADRAO,
  parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  localparam int unsigned PW          = larguraPtr(PROFUNDIDADE),
  localparam int unsigned IW          = larguraIdx(PROFUNDIDADE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dadoPush,
  output logic [LARGURA-1:0] topo,
  output logic [PW-1:0]      ptr,
  output logic               vazio,
  output logic               cheio
);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [IW-1:0]      idxEscrita;
  logic [IW-1:0]      idxTopo;
  logic               fazPush;
  logic               fazPop;

  assign vazio = (ptr == '0);
  assign cheio = (ptr == PW'(PROFUNDIDADE));

  // Pop wins if both are ever requested together.
  assign fazPop  = pop && !vazio;
  assign fazPush = push && !pop && !cheio;

  assign idxEscrita = IW'(ptr);
  assign idxTopo    = IW'(ptr - PW'(1));
  assign topo       = mem[idxTopo];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (fazPop) begin
      ptr <= ptr - PW'(1);
    end else if (fazPush) begin
      ptr <= ptr + PW'(1);
    end
  end

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (fazPush) begin
      mem[idxEscrita] <= dadoPush;
    end
  end

endmodule

// File: rtl/pc_pilha.sv
// Registered program counter with increment, branch, call and return.
// Optional sticky overflow/underflow flag compiled in with PC_PILHA_ERRO_EN.
module pc_pilha
  import pc_pkg::*;
#(
  parameter int unsigned LARGURA      = LARGURA_PADRAO,
  parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int unsigned RESET_END    = RESET_END_PADRAO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               habilita,
  input  logic               desvio,
  input  logic               chamada,
  input  logic               retorno,
  input  logic [LARGURA-1:0] novoEnd,
  output logic [LARGURA-1:0] endAtual,
  output logic               vazio,
  output logic               cheio,
  output logic               erro
);

  localparam int unsigned PW = larguraPtr(PROFUNDIDADE);

  selEnd_t            sel;
  logic [LARGURA-1:0] endInc;
  logic [LARGURA-1:0] proxEnd;
  logic [LARGURA-1:0] topo;
  logic [PW-1:0]      ptr;
  logic               pilhaVazia;

  always_comb begin
    sel = SEL_ESPERA;
    if (habilita) begin
      if (retorno) begin
        sel = SEL_RETORNO;
      end else if (chamada) begin
        sel = SEL_CHAMADA;
      end else if (desvio) begin
        sel = SEL_DESVIO;
      end else begin
        sel = SEL_INC;
      end
    end
  end

  assign endInc     = endAtual + LARGURA'(1);
  assign pilhaVazia = (ptr == '0);

  // An empty-stack return falls through to a plain increment.
  always_comb begin
    proxEnd = endAtual;
    case (sel)
      SEL_INC:     proxEnd = endInc;
      SEL_DESVIO:  proxEnd = novoEnd;
      SEL_CHAMADA: proxEnd = novoEnd;
      SEL_RETORNO: proxEnd = pilhaVazia ? endInc : topo;
      default:     proxEnd = endAtual;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      endAtual <= LARGURA'(RESET_END);
    end else begin
      endAtual <= proxEnd;
    end
  end

  pilha_retorno #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) uPilha (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (sel == SEL_CHAMADA),
    .pop      (sel == SEL_RETORNO),
    .dadoPush (endInc),
    .topo     (topo),
    .ptr      (ptr),
    .vazio    (vazio),
    .cheio    (cheio)
  );

`ifdef PC_PILHA_ERRO_EN
  logic estouro;
  logic esvaziamento;
  logic erroReg;

  assign estouro      = (sel == SEL_CHAMADA) && cheio;
  assign esvaziamento = (sel == SEL_RETORNO) && pilhaVazia;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      erroReg <= 1'b0;
    end else if (estouro || esvaziamento) begin
      erroReg <= 1'b1;
    end
  end

  assign erro = erroReg;
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_pc_pilha.sv
// Bench for pc_pilha: directed vector table plus random stimulus against a
// queue-based reference model. Honours PC_PILHA_ERRO_EN for the erro output.
module tb_pc_pilha;

`ifdef PC_PILHA_ERRO_EN
  localparam bit ERRO_EN = 1'b1;
`else
  localparam bit ERRO_EN = 1'b0;
`endif

  localparam int PROF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       habilita = 1'b0;
  logic       desvio = 1'b0;
  logic       chamada = 1'b0;
  logic       retorno = 1'b0;
  logic [7:0] novoEnd = 8'h00;
  logic [7:0] endAtual;
  logic       vazio;
  logic       cheio;
  logic       erro;

  pc_pilha #(
    .LARGURA      (8),
    .PROFUNDIDADE (PROF),
    .RESET_END    (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .habilita (habilita),
    .desvio   (desvio),
    .chamada  (chamada),
    .retorno  (retorno),
    .novoEnd  (novoEnd),
    .endAtual (endAtual),
    .vazio    (vazio),
    .cheio    (cheio),
    .erro     (erro)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  // Reference model state
  int mEnd = 0;
  bit mErro = 1'b0;
  int mPilha[$];

  typedef struct {
    bit       r;
    bit       h;
    bit       d;
    bit       c;
    bit       rt;
    bit [7:0] novo;
    bit [7:0] expEnd;
    bit       expV;
    bit       expC;
    bit       expE;
  } vetor_t;

  vetor_t vetores[$];

  task automatic addVec(bit r, bit h, bit d, bit c, bit rt, bit [7:0] novo,
                        bit [7:0] expEnd, bit expV, bit expC, bit expE);
    vetor_t v;
    v.r = r; v.h = h; v.d = d; v.c = c; v.rt = rt; v.novo = novo;
    v.expEnd = expEnd; v.expV = expV; v.expC = expC; v.expE = expE;
    vetores.push_back(v);
  endtask

  task automatic check(string nome, int got, int exp);
    nCmp++;
    if (got != exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, got, exp, $time);
    end
  endtask

  task automatic modelo(bit r, bit h, bit d, bit c, bit rt, bit [7:0] novo);
    if (!r) begin
      mEnd = 0;
      mPilha.delete();
      mErro = 1'b0;
    end else if (h) begin
      if (rt) begin
        if (mPilha.size() > 0) begin
          mEnd = mPilha.pop_back();
        end else begin
          mEnd = (mEnd + 1) % 256;
          mErro = 1'b1;
        end
      end else if (c) begin
        if (mPilha.size() < PROF) mPilha.push_back((mEnd + 1) % 256);
        else mErro = 1'b1;
        mEnd = int'(novo);
      end else if (d) begin
        mEnd = int'(novo);
      end else begin
        mEnd = (mEnd + 1) % 256;
      end
    end
  endtask

  task automatic step(string nome, bit r, bit h, bit d, bit c, bit rt, bit [7:0] novo);
    rst_n = r; habilita = h; desvio = d; chamada = c; retorno = rt; novoEnd = novo;
    @(posedge clk);
    modelo(r, h, d, c, rt, novo);
    #1;
    check({nome, ".modelo.endAtual"}, int'(endAtual), mEnd);
    check({nome, ".modelo.vazio"}, int'(vazio), int'(mPilha.size() == 0));
    check({nome, ".modelo.cheio"}, int'(cheio), int'(mPilha.size() == PROF));
    check({nome, ".modelo.erro"}, int'(erro), int'(ERRO_EN && mErro));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // r h d c rt novo | endAtual vazio cheio erro(if enabled)
    addVec(0,0,0,0,0,8'h00, 8'h00,1,0,0);
    addVec(0,1,1,1,1,8'h55, 8'h00,1,0,0);
    addVec(1,1,0,0,0,8'h00, 8'h01,1,0,0);
    addVec(1,1,0,0,0,8'h00, 8'h02,1,0,0);
    addVec(1,1,0,0,0,8'h00, 8'h03,1,0,0);
    addVec(1,1,1,0,0,8'hFE, 8'hFE,1,0,0);
    addVec(1,1,0,0,0,8'h00, 8'hFF,1,0,0);
    addVec(1,1,0,0,0,8'h00, 8'h00,1,0,0);
    addVec(1,1,1,0,0,8'h10, 8'h10,1,0,0);
    addVec(1,1,0,1,0,8'h40, 8'h40,0,0,0);
    addVec(1,1,0,0,0,8'h00, 8'h41,0,0,0);
    addVec(1,1,0,0,1,8'h00, 8'h11,1,0,0);
    addVec(1,1,0,1,0,8'h80, 8'h80,0,0,0);
    addVec(1,1,0,1,0,8'h90, 8'h90,0,0,0);
    addVec(1,1,0,1,0,8'hA0, 8'hA0,0,0,0);
    addVec(1,1,0,1,0,8'hB0, 8'hB0,0,1,0);
    addVec(1,1,0,1,0,8'hC0, 8'hC0,0,1,1);
    addVec(1,1,0,0,1,8'h00, 8'hA1,0,0,1);
    addVec(1,1,0,0,1,8'h00, 8'h91,0,0,1);
    addVec(1,1,0,0,1,8'h00, 8'h81,0,0,1);
    addVec(1,1,0,0,1,8'h00, 8'h12,1,0,1);
    addVec(0,1,0,0,0,8'h00, 8'h00,1,0,0);
    addVec(1,1,1,0,0,8'h20, 8'h20,1,0,0);
    addVec(1,1,0,0,1,8'h00, 8'h21,1,0,1);
    addVec(1,1,0,0,0,8'h00, 8'h22,1,0,1);
    addVec(1,1,1,0,0,8'h55, 8'h55,1,0,1);
    addVec(0,1,0,0,0,8'h00, 8'h00,1,0,0);
    addVec(1,1,0,1,0,8'h30, 8'h30,0,0,0);
    addVec(1,0,0,1,0,8'h77, 8'h30,0,0,0);
    addVec(1,0,0,0,1,8'h00, 8'h30,0,0,0);
    addVec(1,1,1,1,1,8'h99, 8'h01,1,0,0);
    addVec(1,1,0,0,0,8'h00, 8'h02,1,0,0);
    addVec(1,1,0,1,0,8'h70, 8'h70,0,0,0);
    addVec(1,1,0,0,1,8'h00, 8'h03,1,0,0);
    addVec(1,1,0,1,0,8'h50, 8'h50,0,0,0);
    addVec(1,1,0,1,0,8'h60, 8'h60,0,0,0);
    addVec(0,1,0,0,1,8'h00, 8'h00,1,0,0);
    addVec(1,1,0,0,1,8'h00, 8'h01,1,0,1);
    addVec(1,0,0,0,0,8'h00, 8'h01,1,0,1);

    foreach (vetores[i]) begin
      vetor_t v;
      v = vetores[i];
      step($sformatf("vec%0d", i), v.r, v.h, v.d, v.c, v.rt, v.novo);
      check($sformatf("vec%0d.endAtual", i), int'(endAtual), int'(v.expEnd));
      check($sformatf("vec%0d.vazio", i), int'(vazio), int'(v.expV));
      check($sformatf("vec%0d.cheio", i), int'(cheio), int'(v.expC));
      check($sformatf("vec%0d.erro", i), int'(erro), int'(ERRO_EN && v.expE));
    end

    for (int k = 0; k < 600; k++) begin
      bit r, h, d, c, rt;
      r  = ($urandom_range(0, 49) != 0);
      h  = ($urandom_range(0, 4) != 0);
      d  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 3) == 0);
      step($sformatf("rnd%0d", k), r, h, d, c, rt, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
